// File: rtl/lr35902_pkg.sv
// lr35902_pkg: shared constants and types for the LR35902 bus-side blocks
package lr35902_pkg;
  localparam logic [15:0] OAM_DMA_REG = 16'hFF46;
  localparam logic [15:0] IO_BASE = 16'hFF00;
  localparam logic [7:0] DMA_FOLD_BASE = 8'hE0;
  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_e;
  // Echo RAM pages 0xE0..0xFF alias work RAM 0xC0..0xDF
  function automatic logic [7:0] dma_src_fold(input logic [7:0] src);
    return (src >= DMA_FOLD_BASE) ? src - 8'h20 : src;
  endfunction
endpackage

// File: rtl/lr35902_oam_dma.sv
// lr35902_oam_dma: OAM DMA engine and bus-master address mux feeding the address decoder
module lr35902_oam_dma
  import lr35902_pkg::*;
#(
  parameter int LEN = 160,
  parameter logic [7:0] REG_RESET = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_adr,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic [7:0]  dma_din,
  output logic [15:0] adr,
  output logic        dma_active,
  output logic        cpu_block,
  output logic        oam_we,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout
);
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
  dma_state_e state_q;
  logic [7:0] idx_q, src_hi_q, oam_adr_q, oam_dout_q;
  logic       oam_we_q, fire, last;
  // A register write swallows a coincident ce, so nothing is sampled on that edge
  assign fire = (state_q == XFER) && ce && !reg_wr;
  assign last = idx_q == LAST_IDX;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      src_hi_q   <= REG_RESET;
      oam_we_q   <= 1'b0;
      oam_adr_q  <= '0;
      oam_dout_q <= '0;
    end else begin
      oam_we_q <= fire;
      if (fire) begin
        oam_adr_q  <= idx_q;
        oam_dout_q <= dma_din;
      end
      if (reg_wr) begin
        src_hi_q <= reg_din;
        idx_q    <= '0;
        state_q  <= START;
      end else if (ce) begin
        if (state_q == START) state_q <= XFER;
        else if (state_q == XFER) begin
          idx_q <= last ? 8'h00 : idx_q + 8'h01;
          if (last) state_q <= IDLE;
        end
      end
    end
  // The final write strobe lands after the engine has already returned to IDLE
  assign dma_active = (state_q == XFER) || oam_we_q;
  assign cpu_block  = dma_active && (cpu_adr < IO_BASE);
  assign adr        = (state_q == XFER) ? {dma_src_fold(src_hi_q), idx_q} : cpu_adr;
  assign reg_dout   = src_hi_q;
  assign oam_we     = oam_we_q;
  assign oam_adr    = oam_adr_q;
  assign oam_dout   = oam_dout_q;
endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb_lr35902_oam_dma: directed checks of the OAM DMA engine against hand-computed values
module tb_lr35902_oam_dma;
  logic        clk, reset, ce, reg_wr;
  logic [15:0] cpu_adr, adr;
  logic [7:0]  reg_din, reg_dout, dma_din, oam_adr, oam_dout;
  logic        dma_active, cpu_block, oam_we;
  int          errors = 0, checks = 0, we_cnt = 0, base;
  logic [15:0] blk_adr [3] = '{16'h8000, 16'hFF80, 16'hFF46};
  logic        blk_exp [3] = '{1'b1, 1'b0, 1'b0};

  lr35902_oam_dma dut (
    .clk(clk), .reset(reset), .ce(ce), .cpu_adr(cpu_adr), .reg_wr(reg_wr),
    .reg_din(reg_din), .reg_dout(reg_dout), .dma_din(dma_din), .adr(adr),
    .dma_active(dma_active), .cpu_block(cpu_block), .oam_we(oam_we),
    .oam_adr(oam_adr), .oam_dout(oam_dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign dma_din = adr[7:0] ^ 8'h5A;
  always @(negedge clk) if (oam_we) we_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mcycle();
    ce = 1; @(negedge clk); ce = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer_cycle(input logic [7:0] hi, input int i);
    check("dma_adr", adr, {hi, 8'(i)});
    ce = 1; @(negedge clk); ce = 0;
    check("oam_we_hi", {15'd0, oam_we}, 16'd1);
    check("oam_adr", {8'd0, oam_adr}, {8'd0, 8'(i)});
    check("oam_dout", {8'd0, oam_dout}, {8'd0, 8'(i) ^ 8'h5A});
    check("active_wr", {15'd0, dma_active}, 16'd1);
    @(negedge clk);
    check("oam_we_lo", {15'd0, oam_we}, 16'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1; ce = 0; reg_wr = 0; reg_din = 0; cpu_adr = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_we", {15'd0, oam_we}, 16'd0);
    check("rst_oam_adr", {8'd0, oam_adr}, 16'd0);
    check("rst_oam_dout", {8'd0, oam_dout}, 16'd0);
    check("rst_active", {15'd0, dma_active}, 16'd0);
    check("rst_block", {15'd0, cpu_block}, 16'd0);
    check("rst_reg", {8'd0, reg_dout}, 16'h00FF);
    check("rst_adr", adr, 16'h1234);
    reset = 0; @(negedge clk);
    // basic copy from 0xC100 with a start delay held by missing ce
    base = we_cnt;
    reg_din = 8'hC1; reg_wr = 1; @(negedge clk); reg_wr = 0;
    check("start_adr", adr, 16'h1234);
    check("start_active", {15'd0, dma_active}, 16'd0);
    check("start_reg", {8'd0, reg_dout}, 16'h00C1);
    repeat (5) @(negedge clk);
    check("freeze_adr", adr, 16'h1234);
    check("freeze_we", {15'd0, oam_we}, 16'd0);
    ce = 1; @(negedge clk); ce = 0;
    check("start_ce_we", {15'd0, oam_we}, 16'd0);
    check("first_adr", adr, 16'hC100);
    check("xfer_active", {15'd0, dma_active}, 16'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 160; i++) begin
      if (i >= 10 && i <= 12) begin
        cpu_adr = blk_adr[i-10];
        #1 check("cpu_block", {15'd0, cpu_block}, {15'd0, blk_exp[i-10]});
      end
      if (i == 13) cpu_adr = 16'h1234;
      xfer_cycle(8'hC1, i);
    end
    check("done_active", {15'd0, dma_active}, 16'd0);
    check("done_adr", adr, 16'h1234);
    check("done_cnt", 16'(we_cnt - base), 16'd160);
    check("done_reg", {8'd0, reg_dout}, 16'h00C1);
    check("hold_oam_adr", {8'd0, oam_adr}, 16'h009F);
    check("hold_oam_dout", {8'd0, oam_dout}, 16'h00C5);
    // restart at idx 50 while the write for index 49 is still pending
    reg_din = 8'h40; reg_wr = 1; @(negedge clk); reg_wr = 0;
    mcycle();
    for (int i = 0; i < 49; i++) xfer_cycle(8'h40, i);
    check("pre_restart_adr", adr, 16'h4031);
    ce = 1; @(negedge clk); ce = 0;
    reg_din = 8'h80; reg_wr = 1;
    check("pend_we", {15'd0, oam_we}, 16'd1);
    check("pend_adr", {8'd0, oam_adr}, 16'h0031);
    check("pend_dout", {8'd0, oam_dout}, 16'h006B);
    @(negedge clk); reg_wr = 0;
    check("rs_we", {15'd0, oam_we}, 16'd0);
    check("rs_active", {15'd0, dma_active}, 16'd0);
    check("rs_adr", adr, 16'h1234);
    check("rs_reg", {8'd0, reg_dout}, 16'h0080);
    repeat (3) @(negedge clk);
    ce = 1; @(negedge clk); ce = 0;
    check("rs_start_we", {15'd0, oam_we}, 16'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) xfer_cycle(8'h80, i);
    // asynchronous reset between clock edges at idx 100
    base = we_cnt;
    cpu_adr = 16'h8000;
    #1 check("pre_rst_block", {15'd0, cpu_block}, 16'd1);
    check("pre_rst_adr", adr, 16'h8064);
    ce = 1; @(negedge clk); ce = 0;
    check("pre_rst_we", {15'd0, oam_we}, 16'd1);
    #2 reset = 1;
    #1 check("arst_we", {15'd0, oam_we}, 16'd0);
    check("arst_active", {15'd0, dma_active}, 16'd0);
    check("arst_block", {15'd0, cpu_block}, 16'd0);
    check("arst_reg", {8'd0, reg_dout}, 16'h00FF);
    check("arst_adr", adr, 16'h8000);
    @(negedge clk);
    mcycle(); mcycle();
    reset = 0;
    repeat (4) mcycle();
    check("post_rst_cnt", 16'(we_cnt - base), 16'd1);
    check("post_rst_active", {15'd0, dma_active}, 16'd0);
    check("post_rst_adr", adr, 16'h8000);
    // echo fold and reg_wr coincident with ce in START and in XFER
    cpu_adr = 16'h1234;
    reg_din = 8'hE3; reg_wr = 1; @(negedge clk); reg_wr = 0;
    ce = 1; reg_wr = 1; @(negedge clk); ce = 0; reg_wr = 0;
    check("co_start_adr", adr, 16'h1234);
    check("co_start_active", {15'd0, dma_active}, 16'd0);
    check("fold_reg", {8'd0, reg_dout}, 16'h00E3);
    repeat (3) @(negedge clk);
    mcycle();
    for (int i = 0; i < 3; i++) xfer_cycle(8'hC3, i);
    ce = 1; reg_wr = 1; @(negedge clk); ce = 0; reg_wr = 0;
    check("co_xfer_we", {15'd0, oam_we}, 16'd0);
    check("co_xfer_active", {15'd0, dma_active}, 16'd0);
    check("co_xfer_adr", adr, 16'h1234);
    repeat (3) @(negedge clk);
    mcycle();
    for (int i = 0; i < 2; i++) xfer_cycle(8'hC3, i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lr35902_oam_dma.md
Name: lr35902_oam_dma

Overview:
- OAM DMA engine plus bus-master address mux. It sits directly upstream of the address decoder and owns the 16-bit `adr` that the decoder sees.
- A write to register 0xFF46 copies 160 bytes from `{src_hi,0x00}..{src_hi,0x9F}` into OAM 0x00..0x9F.
- One byte is copied per machine cycle.
- While the copy runs, CPU accesses below 0xFF00 are blocked.

Parameters:
- LEN, 160: number of bytes per transfer (1..256).
- REG_RESET, 8'hFF: reset value of the source register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  machine-cycle enable; one clk-wide pulse per M-cycle
- cpu_adr  in  16  CPU bus address
- reg_wr  in  1  one-clk write strobe for 0xFF46, decoded by the I/O block
- reg_din  in  8  write data for 0xFF46
- reg_dout  out  8  readback value of 0xFF46 (last written value)
- dma_din  in  8  read data returned for the address `adr`; valid when ce=1
- adr  out  16  muxed bus address driven to the address decoder
- dma_active  out  1  high while a copy owns the bus
- cpu_block  out  1  CPU access must be ignored: reads return 0xFF, writes are dropped
- oam_we  out  1  one-clk OAM write strobe
- oam_adr  out  8  OAM byte index
- oam_dout  out  8  OAM write data

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, idx=0, src_hi=REG_RESET.
  - oam_we=0, oam_adr=0, oam_dout=0.
  - dma_active=0, cpu_block=0.
  - reg_dout=REG_RESET; adr follows cpu_adr.
- Reset asserted mid-transfer aborts the copy immediately; no further oam_we pulses occur.
- State machine:
  - IDLE: on reg_wr, go to START.
  - START: on ce, go to XFER. This gives one full M-cycle of start delay.
  - XFER: on each ce, sample `buf<=dma_din`, `wadr<=idx`, set wr_pend, then idx++.
    - On the ce where idx==LEN-1, go to IDLE (idx resets to 0).
- Register write (any state):
  - On reg_wr: src_hi<=reg_din, reg_dout<=reg_din, idx<=0, state<=START.
  - reg_wr has priority over a coincident ce: the ce is consumed, nothing is sampled and idx does not advance.
  - A write during XFER restarts the copy from index 0 with the new source.
  - An already pending OAM write still completes.
- Source fold: effective high byte src_eff = (src_hi >= 8'hE0) ? src_hi - 8'h20 : src_hi, so 0xE0..0xFF map onto 0xC0..0xDF.
- Address mux (combinational):
  - In XFER: adr = {src_eff, idx}.
  - Otherwise: adr = cpu_adr.
- OAM write:
  - oam_we is high for exactly the one clk following each XFER ce, with oam_adr=wadr and oam_dout=buf.
  - oam_adr and oam_dout hold their value when oam_we=0.
- dma_active:
  - High in XFER.
  - Also high for the one clk carrying the final oam_we.
  - Low in IDLE and START.
- cpu_block = dma_active && cpu_adr < 16'hFF00. HRAM and I/O stay accessible, so the CPU can poll and rewrite 0xFF46.
- Width and latency:
  - idx is 8 bits; with LEN=256 it wraps 0xFF->0x00 exactly at completion.
  - Total duration from reg_wr to the last oam_we: 1 + LEN M-cycles plus 1 clk.
- ce held low freezes the engine in its current state. There is no timeout.

Decomposition:
- Shared package lr35902_pkg holds:
  - OAM_DMA_REG = 16'hFF46
  - IO_BASE = 16'hFF00
  - DMA_FOLD_BASE = 8'hE0
  - the DMA state enum (IDLE, START, XFER)
- No sub-module. The counter, buffer and mux are small enough to stay in one module.

Test Plan:
- Basic copy:
  - Stimulus: after reset, reg_wr with reg_din=8'hC1; ce every 4 clk; model returns dma_din=adr[7:0]^8'h5A.
  - Required: adr steps through 16'hC100..16'hC19F; 160 oam_we pulses with oam_adr 0..159 and oam_dout=idx^8'h5A; dma_active drops after the last write; reg_dout=8'hC1.
- Start delay:
  - Stimulus: reg_wr, then the first ce.
  - Required: no oam_we and adr==cpu_adr during START; the first read address 16'hC100 appears only after that ce.
- CPU blocking:
  - Stimulus: during XFER, cpu_adr=16'h8000, then 16'hFF80, then 16'hFF46.
  - Required: cpu_block=1, then 0, then 0.
- Restart mid-transfer:
  - Stimulus: at idx=50, reg_wr with reg_din=8'h80.
  - Required: the pending write for index 49 completes; after one START M-cycle, reads restart at 16'h8000 with oam_adr=0.
- Echo fold and simultaneous events:
  - Stimulus: reg_din=8'hE3; also reg_wr coincident with ce.
  - Required: adr high byte = 8'hC3; the coincident ce does not advance idx.
- Asynchronous reset:
  - Stimulus: assert reset at idx=100 between clk edges.
  - Required: oam_we and dma_active fall immediately; reg_dout=8'hFF; adr==cpu_adr.
